// File: rtl/alu_issue_if.sv
// Handshake and ALU-side bundle for alu_issue: request channel, ALU operand/result
// channel and retire channel. The slave modport is the alu_issue view.
interface alu_issue_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       aluop;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;

    logic [WIDTH-1:0] alu_op1;
    logic [WIDTH-1:0] alu_op2;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_ops;
    logic             alu_zf;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             err;

    modport master (
        output in_valid, aluop, funct, a, b, alu_ops, alu_zf, out_ready,
        input  in_ready, alu_op1, alu_op2, alu_op, out_valid, result, zero, err
    );

    modport slave (
        input  in_valid, aluop, funct, a, b, alu_ops, alu_zf, out_ready,
        output in_ready, alu_op1, alu_op2, alu_op, out_valid, result, zero, err
    );
endinterface

// File: rtl/alu_issue.sv
// Issue/retire front end for the 32-bit combinational ALU: decode, issue register (S1), retire register (S2).
// Define ALU_ISSUE_BYPASS_EN to remove S1 and drive the ALU straight from the decoded input.
module alu_issue #(
    parameter int unsigned WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    alu_issue_if.slave bus
);
    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_SLT = 3'b100,
        OP_DIV = 3'b101,
        OP_NOP = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    alu_op_e dec_op;
    logic    dec_ill;
    logic    dec_dz;
    logic    s2_free;
    logic    in_fire;
    logic    cap_fire;
    logic    cap_ill;
    logic    cap_dz;

    // ALUOP/funct translation of the request currently on the input
    always_comb begin
        dec_op  = OP_NOP;
        dec_ill = 1'b0;
        case (bus.aluop)
            2'b00:   dec_op = OP_ADD;
            2'b01:   dec_op = OP_SUB;
            2'b11:   dec_op = OP_OR;
            default: begin
                case (bus.funct)
                    6'b100000: dec_op = OP_ADD;
                    6'b100010: dec_op = OP_SUB;
                    6'b100100: dec_op = OP_AND;
                    6'b100101: dec_op = OP_OR;
                    6'b101010: dec_op = OP_SLT;
                    6'b011010: dec_op = OP_DIV;
                    6'b011000: dec_op = OP_MUL;
                    default: begin
                        dec_op  = OP_NOP;
                        dec_ill = 1'b1;
                    end
                endcase
            end
        endcase
    end

    assign dec_dz  = (dec_op == OP_DIV) && (bus.b == '0);
    assign s2_free = !bus.out_valid || bus.out_ready;

`ifdef ALU_ISSUE_BYPASS_EN
    assign bus.in_ready = s2_free;
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign bus.alu_op   = dec_op;
    assign bus.alu_op1  = bus.a;
    assign bus.alu_op2  = bus.b;
    assign cap_fire     = in_fire;
    assign cap_ill      = dec_ill;
    assign cap_dz       = dec_dz;
`else
    logic             s1_valid;
    alu_op_e          s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_ill;
    logic             s1_dz;

    assign bus.in_ready = !s1_valid || s2_free;
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign cap_fire     = s1_valid && s2_free;
    assign cap_ill      = s1_ill;
    assign cap_dz       = s1_dz;

    // Issue register; data only loads on acceptance so the ALU inputs stay quiet when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_AND;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_ill   <= 1'b0;
            s1_dz    <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_op  <= dec_op;
                s1_a   <= bus.a;
                s1_b   <= bus.b;
                s1_ill <= dec_ill;
                s1_dz  <= dec_dz;
            end
            if (in_fire) begin
                s1_valid <= 1'b1;
            end else if (cap_fire) begin
                s1_valid <= 1'b0;
            end
        end
    end

    assign bus.alu_op  = s1_op;
    assign bus.alu_op1 = s1_a;
    assign bus.alu_op2 = s1_b;
`endif

    // Retire register; illegal and divide-by-zero results override the ALU output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.zero      <= 1'b0;
            bus.err       <= 1'b0;
        end else if (cap_fire) begin
            bus.out_valid <= 1'b1;
            if (cap_ill) begin
                bus.result <= '0;
                bus.zero   <= 1'b1;
                bus.err    <= 1'b1;
            end else if (cap_dz) begin
                bus.result <= '1;
                bus.zero   <= 1'b0;
                bus.err    <= 1'b1;
            end else begin
                bus.result <= bus.alu_ops;
                bus.zero   <= bus.alu_zf;
                bus.err    <= 1'b0;
            end
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue with a behavioural ALU on the operand/result channel.
// Also builds with ALU_ISSUE_BYPASS_EN defined; timing-specific checks adapt.
module tb_alu_issue;
    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   nchecks = 0;
    int   nerr = 0;
    int   cyc = 0;
    int   stalls = 0;
    bit   bp_done;
    exp_t expq[$];
    int   rc[$];
    logic [31:0] alu_res;

    alu_issue_if #(.WIDTH(32)) bus ();

    alu_issue #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU; nop returns junk to prove the retire stage ignores it
    always_comb begin
        case (bus.alu_op)
            3'b000:  alu_res = bus.alu_op1 & bus.alu_op2;
            3'b001:  alu_res = bus.alu_op1 | bus.alu_op2;
            3'b010:  alu_res = bus.alu_op1 + bus.alu_op2;
            3'b011:  alu_res = bus.alu_op1 - bus.alu_op2;
            3'b100:  alu_res = ($signed(bus.alu_op1) < $signed(bus.alu_op2)) ? 32'd1 : 32'd0;
            3'b101:  alu_res = (bus.alu_op2 == 32'd0) ? 32'h1234_5678 : bus.alu_op1 / bus.alu_op2;
            3'b111:  alu_res = bus.alu_op1 * bus.alu_op2;
            default: alu_res = 32'hDEAD_BEEF;
        endcase
        bus.alu_ops = alu_res;
        bus.alu_zf  = (alu_res == 32'd0);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Retire monitor: a handshake completes at the next edge
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            rc.push_back(cyc);
            if (expq.size() == 0) begin
                nchecks++;
                nerr++;
                $display("FAIL retire: unexpected result %h with empty scoreboard", bus.result);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("retire.result", bus.result, e.res);
                chk("retire.zero", 32'(bus.zero), 32'(e.zero));
                chk("retire.err", 32'(bus.err), 32'(e.err));
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] er, input logic ez, input logic ee);
        bit acc;
        int tries;
        exp_t e;
        bus.in_valid = 1'b1;
        bus.aluop    = op;
        bus.funct    = fn;
        bus.a        = av;
        bus.b        = bv;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 50) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        if (!acc) begin
            nchecks++;
            nerr++;
            $display("FAIL issue.timeout: request a=%h b=%h never accepted", av, bv);
        end else begin
            if (tries > 1) stalls++;
            e.res  = er;
            e.zero = ez;
            e.err  = ee;
            expq.push_back(e);
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(posedge clk);
            #1;
            done = (expq.size() == 0) && !bus.out_valid;
        end
        chk({nm, ".drained"}, 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.aluop     = 2'b00;
        bus.funct     = 6'd0;
        bus.a         = 32'd0;
        bus.b         = 32'd0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset.result", bus.result, 32'd0);
        chk("reset.zero", 32'(bus.zero), 32'd0);
        chk("reset.err", 32'(bus.err), 32'd0);
        chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
`ifndef ALU_ISSUE_BYPASS_EN
        chk("reset.alu_op", 32'(bus.alu_op), 32'd0);
        chk("reset.alu_op1", bus.alu_op1, 32'd0);
        chk("reset.alu_op2", bus.alu_op2, 32'd0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single R-type add with latency check
        issue(2'b10, 6'b100000, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
`ifndef ALU_ISSUE_BYPASS_EN
        chk("add.alu_op", 32'(bus.alu_op), 32'b010);
        chk("add.alu_op1", bus.alu_op1, 32'd5);
        chk("add.alu_op2", bus.alu_op2, 32'd7);
        idle();
        @(posedge clk);
        #1;
`else
        idle();
`endif
        chk("add.out_valid", 32'(bus.out_valid), 32'd1);
        chk("add.result", bus.result, 32'd12);
        drain("add");

        // Back-to-back throughput
        rc.delete();
        stalls = 0;
        issue(2'b10, 6'b100010, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0);
        issue(2'b10, 6'b101010, 32'd3, 32'd4, 32'd1, 1'b0, 1'b0);
        issue(2'b10, 6'b011000, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0);
        idle();
        chk("b2b.stalls", 32'(stalls), 32'd0);
        drain("b2b");
        chk("b2b.count", 32'(rc.size()), 32'd3);
        if (rc.size() == 3) chk("b2b.spacing", 32'(rc[2] - rc[0]), 32'd2);

        // Divide-by-zero, illegal funct and remaining decode paths
        issue(2'b10, 6'b011010, 32'd10, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
        issue(2'b10, 6'b111111, 32'd1, 32'd2, 32'd0, 1'b1, 1'b1);
`ifndef ALU_ISSUE_BYPASS_EN
        chk("illegal.alu_op", 32'(bus.alu_op), 32'b110);
`endif
        issue(2'b00, 6'b000000, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0);
        issue(2'b01, 6'b000000, 32'd4, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0);
        issue(2'b11, 6'b000000, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0);
        issue(2'b10, 6'b100100, 32'hFF, 32'h0F, 32'h0F, 1'b0, 1'b0);
        issue(2'b10, 6'b100101, 32'h30, 32'h03, 32'h33, 1'b0, 1'b0);
        issue(2'b10, 6'b011010, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0);
        issue(2'b10, 6'b101010, 32'd5, 32'd3, 32'd0, 1'b1, 1'b0);
        idle();
        drain("decode");

        // Back-pressure: first result frozen, second in S1, third stalled
        bus.out_ready = 1'b0;
        rc.delete();
        bp_done = 1'b0;
        fork
            begin
                issue(2'b00, 6'd0, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
                issue(2'b00, 6'd0, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0);
                issue(2'b00, 6'd0, 32'd3, 32'd3, 32'd6, 1'b0, 1'b0);
                idle();
                bp_done = 1'b1;
            end
        join_none
        repeat (6) @(posedge clk);
        #1;
        chk("bp.in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp.out_valid", 32'(bus.out_valid), 32'd1);
        chk("bp.result", bus.result, 32'd2);
        repeat (2) @(posedge clk);
        #1;
        chk("bp.result_hold", bus.result, 32'd2);
        chk("bp.in_ready_hold", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 50 && !bp_done; i++) begin
            @(posedge clk);
            #1;
        end
        chk("bp.issue_done", 32'(bp_done), 32'd1);
        drain("bp");
        chk("bp.count", 32'(rc.size()), 32'd3);
        if (rc.size() == 3) chk("bp.spacing", 32'(rc[2] - rc[0]), 32'd2);

        // Asynchronous reset with S1 and S2 occupied
        bus.out_ready = 1'b0;
        issue(2'b11, 6'd0, 32'd5, 32'd3, 32'd7, 1'b0, 1'b0);
`ifndef ALU_ISSUE_BYPASS_EN
        issue(2'b10, 6'b011000, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0);
        chk("prerst.alu_op", 32'(bus.alu_op), 32'b111);
`endif
        idle();
        chk("prerst.out_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.result", bus.result, 32'd0);
        chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
`ifndef ALU_ISSUE_BYPASS_EN
        chk("rst.alu_op", 32'(bus.alu_op), 32'd0);
        chk("rst.alu_op1", bus.alu_op1, 32'd0);
`endif
        expq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst.out_valid", 32'(bus.out_valid), 32'd0);
        issue(2'b00, 6'd0, 32'd20, 32'd22, 32'd42, 1'b0, 1'b0);
        idle();
        drain("postrst");

        chk("end.scoreboard_empty", 32'(expq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end
endmodule

// File: doc/alu_issue.md
# alu_issue

Two-stage issue/retire front end for the 32-bit combinational ALU. It accepts decoded instruction fields and register operands over a valid/ready handshake, translates ALUOp/funct into the ALU's 3-bit operation code, drives the ALU from a registered issue stage, and captures the ALU result and zero flag into a retire register. It sits between the register-file read stage and writeback. It is the driving end of the ALU's OP1/OP2/OP interface.

## Interface
- WIDTH, 32, operand and result width; must match the ALU.
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- IN_VALID  in  1  request valid.
- IN_READY  out  1  request accepted when IN_VALID && IN_READY at a CLK edge.
- ALUOP  in  2  main-decoder op class.
- FUNCT  in  6  R-type funct field.
- A, B  in  WIDTH  source operands.
- ALU_OP1, ALU_OP2  out  WIDTH  operands to the ALU.
- ALU_OP  out  3  operation code to the ALU.
- ALU_OPS  in  WIDTH  ALU result.
- ALU_ZF  in  1  ALU zero flag.
- OUT_VALID  out  1  retire register holds a result.
- OUT_READY  in  1  consumer accepts when OUT_VALID && OUT_READY at a CLK edge.
- RESULT  out  WIDTH  retired result.
- ZERO  out  1  retired zero flag.
- ERR  out  1  retired op was illegal or divide-by-zero.

## Operation
- ALUOP decode:
  - 00 -> 010 (add).
  - 01 -> 011 (sub).
  - 11 -> 001 (or).
  - 10 -> funct decode:
    - 100000 -> 010 (add); 100010 -> 011 (sub).
    - 100100 -> 000 (and); 100101 -> 001 (or).
    - 101010 -> 100 (slt); 011010 -> 101 (div); 011000 -> 111 (mul).
    - Any other funct -> 110 (nop), marked illegal.
- Issue stage (S1): registers op code, A, B, an illegal bit and a divide-by-zero bit (op 101 && B == 0). ALU_OP1/ALU_OP2/ALU_OP are driven straight from S1 registers. S1 registers hold their value while S1 is empty; no toggling on idle cycles.
- Retire stage (S2) captures from S1:
  - Normal ops: RESULT = ALU_OPS, ZERO = ALU_ZF, ERR = 0.
  - Illegal op: RESULT = 0, ZERO = 1, ERR = 1. ALU_OPS is ignored, because the ALU does not update on 110.
  - Divide-by-zero: RESULT = all ones, ZERO = 0, ERR = 1. ALU_OPS is ignored.
- Flow control:
  - s2_free = !OUT_VALID || OUT_READY.
  - IN_READY = !s1_valid || s2_free (combinational).
  - S1 advances into S2 when s1_valid && s2_free.
  - A new request loads S1 in the same edge as S1 advances, so full throughput is one op per cycle.
- Back-pressure: OUT_READY low with OUT_VALID high freezes RESULT/ZERO/ERR. S1 holds one more op, then IN_READY drops.
- Reset values: OUT_VALID = 0; s1_valid = 0; RESULT = 0; ZERO = 0; ERR = 0; ALU_OP = 000; ALU_OP1 = 0; ALU_OP2 = 0. IN_READY = 1 after reset.
- Reset mid-operation: all in-flight ops are discarded immediately. No partial result is ever presented.

## Timing
- Latency: a request accepted at edge N loads S1 at N. RESULT/OUT_VALID are valid after edge N+1, provided S2 is free.
- The ALU path (S1 -> ALU -> S2 capture) must close within one CLK period.
- Simultaneous events, same edge: S2 retires (OUT_READY), S1 advances, and a new input loads. All three are legal; no bubble.
- OUT_VALID never drops without an OUT_READY handshake. RESULT/ZERO/ERR are stable while OUT_VALID && !OUT_READY.

## Configuration
- ALU_ISSUE_BYPASS_EN defined:
  - S1 is removed. ALU_OP1/ALU_OP2/ALU_OP are driven combinationally from A, B and the decode of the current input.
  - S2 captures on input handshake.
  - IN_READY = !OUT_VALID || OUT_READY.
  - Latency: result valid after the acceptance edge N.
  - Reset values of S2 outputs are unchanged.
- Undefined: two-stage behaviour as above.

## Test plan
- Reset, then ALUOP=10 FUNCT=100000 A=5 B=7, OUT_READY=1 -> after edge N+1: OUT_VALID=1, RESULT=12, ZERO=0, ERR=0, ALU_OP was 010.
- Back-to-back sub 9-9, slt 3<4, mul 6*7, one per cycle, OUT_READY=1 -> three consecutive results: 0/ZERO=1, 1/ZERO=0, 42/ZERO=0. IN_READY stays 1 throughout.
- ALUOP=10 FUNCT=011010 A=10 B=0 -> RESULT=32'hFFFFFFFF, ZERO=0, ERR=1. ALUOP=10 FUNCT=111111 -> ALU_OP=110, RESULT=0, ZERO=1, ERR=1.
- OUT_READY=0 while issuing 3 adds -> first result held stable, second in S1, IN_READY=0 with the third stalled. Raise OUT_READY -> all three retire in order, one per cycle.
- Assert RST while S1 and S2 are both valid -> OUT_VALID=0, RESULT=0, ALU_OP=000 immediately, with no CLK edge. First post-reset op retires correctly.
- With ALU_ISSUE_BYPASS_EN: add 2+2 accepted at edge N -> RESULT=4 valid after edge N.
